dpi_mem_port: RTL and testbench

- Sequential, handshaked successor to the combinational DPI data-memory block.
- Accepts one load/store request at a time and waits a parametrised number of cycles.
- Issues exactly one clocked pmem_read or pmem_write DPI call per request, then returns a held response.
- Sits between the LSU/fetch stage and the simulator memory model; adds alignment checking and backpressure.

---
 rtl/dpi_mem_pkg.sv | 50 +++++
 rtl/dpi_mem_port_access.sv | 41 ++++
 rtl/dpi_mem_port.sv | 134 +++++++++++++
 tb/tb_dpi_mem_port.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpi_mem_pkg.sv
// Shared types, constants and the simulator memory model behind pmem_read/pmem_write.
// The model is byte-addressed, little-endian; each call moves 8 bytes starting at addr.
package dpi_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DPI_W     = 64;
    localparam int DPI_BYTES = DPI_W / 8;
    localparam int CNT_W     = 4;

    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_w_of(input int data_w);
        return $clog2(bytes_of(data_w));
    endfunction

    // Memory model state; unwritten bytes read as zero.
    logic [7:0]  pmem_bytes [logic [63:0]];
    int unsigned pmem_read_count;
    int unsigned pmem_write_count;

    function automatic logic [63:0] pmem_read(input logic [63:0] raddr);
        logic [63:0] data;
        data = 64'd0;
        for (int i = 0; i < DPI_BYTES; i++) begin
            if (pmem_bytes.exists(raddr + 64'(i))) begin
                data[8*i +: 8] = pmem_bytes[raddr + 64'(i)];
            end
        end
        pmem_read_count = pmem_read_count + 32'd1;
        return data;
    endfunction

    function automatic void pmem_write(input logic [63:0] waddr, input logic [63:0] wdata,
                                       input logic [7:0] wmask);
        for (int i = 0; i < DPI_BYTES; i++) begin
            if (wmask[i]) begin
                pmem_bytes[waddr + 64'(i)] = wdata[8*i +: 8];
            end
        end
        pmem_write_count = pmem_write_count + 32'd1;
    endfunction

endpackage

// File: rtl/dpi_mem_port_access.sv
// Clocked owner of the memory calls: one pmem_read or pmem_write on each fire edge.
import dpi_mem_pkg::*;

module dpi_mem_access #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                fire,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wmask,
    output logic [DATA_W-1:0]   rdata
);

    logic [63:0]       addr64_s;
    logic [63:0]       wdata64_s;
    logic [7:0]        wmask8_s;
    logic [DATA_W-1:0] rdata_r;

    assign addr64_s  = 64'(addr);
    assign wdata64_s = 64'(wdata);
    assign wmask8_s  = 8'(wmask);
    assign rdata     = rdata_r;

    // Perform the access and capture load data; stores leave zero behind.
    always_ff @(posedge clk) begin
        if (fire) begin
            if (we) begin
                pmem_write(addr64_s, wdata64_s, wmask8_s);
                rdata_r <= {DATA_W{1'b0}};
            end else begin
                rdata_r <= DATA_W'(pmem_read(addr64_s));
            end
        end else begin
            rdata_r <= rdata_r;
        end
    end

endmodule

// File: rtl/dpi_mem_port.sv
// Handshaked load/store port: accepts one request, waits LATENCY cycles, makes one
// memory call (none when misaligned) and holds the response until it is taken.
import dpi_mem_pkg::*;

module dpi_mem_port #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wmask,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err
);

    localparam int                OFF_W      = off_w_of(DATA_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0]  CNT_INIT   = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};

    state_e               state_r;
    state_e               state_nx_s;
    logic [CNT_W-1:0]     cnt_r;
    logic                 we_r;
    logic [ADDR_W-1:0]    addr_r;
    logic [DATA_W-1:0]    wdata_r;
    logic [DATA_W/8-1:0]  wmask_r;
    logic                 err_r;
    logic                 req_ready_r;
    logic                 resp_valid_r;
    logic                 resp_err_r;
    logic                 accept_s;
    logic                 misalign_s;
    logic                 fire_s;
    logic [DATA_W-1:0]    access_rdata_s;

    // req_ready_r is only high in IDLE, so it also qualifies acceptance.
    assign accept_s   = req_valid && req_ready_r;
    assign misalign_s = (req_addr & ALIGN_MASK) != {ADDR_W{1'b0}};
    assign fire_s     = (state_r == WAIT) && (cnt_r == CNT_ZERO) && !err_r && !reset;

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = (resp_valid_r && !resp_err_r) ? access_rdata_s : {DATA_W{1'b0}};

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nx_s = WAIT;
                else          state_nx_s = IDLE;
            end
            WAIT: begin
                if (cnt_r == CNT_ZERO) state_nx_s = RESP;
                else                   state_nx_s = WAIT;
            end
            RESP: begin
                if (resp_ready) state_nx_s = IDLE;
                else            state_nx_s = RESP;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State, latency counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            req_ready_r  <= (state_nx_s == IDLE);
            resp_valid_r <= (state_nx_s == RESP);
            resp_err_r   <= (state_nx_s == RESP) && err_r;
            if (accept_s) begin
                cnt_r <= CNT_INIT;
            end else if ((state_r == WAIT) && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Request latch; later changes on req_* cannot disturb an accepted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            wmask_r <= {(DATA_W/8){1'b0}};
            err_r   <= 1'b0;
        end else if (accept_s) begin
            we_r    <= req_we;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            wmask_r <= req_wmask;
            err_r   <= misalign_s;
        end else begin
            we_r    <= we_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            wmask_r <= wmask_r;
            err_r   <= err_r;
        end
    end

    dpi_mem_access #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_access (
        .clk   (clk),
        .fire  (fire_s),
        .we    (we_r),
        .addr  (addr_r),
        .wdata (wdata_r),
        .wmask (wmask_r),
        .rdata (access_rdata_s)
    );

endmodule

// File: tb/tb_dpi_mem_port.sv
// Directed bench: three port instances (64b/L1, 64b/L4, 32b/L1) sharing one memory model.
module tb_dpi_mem_port;
    import dpi_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        a_reset, a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
    logic [63:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic [7:0]  a_req_wmask;
    logic        b_reset, b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
    logic [63:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [7:0]  b_req_wmask;
    logic        c_reset, c_req_valid, c_req_ready, c_req_we, c_resp_valid, c_resp_ready, c_resp_err;
    logic [63:0] c_req_addr;
    logic [31:0] c_req_wdata, c_resp_rdata;
    logic [3:0]  c_req_wmask;

    dpi_mem_port #(.ADDR_W(64), .DATA_W(64), .LATENCY(1)) u_a (
        .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wmask(a_req_wmask),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err));

    dpi_mem_port #(.ADDR_W(64), .DATA_W(64), .LATENCY(4)) u_b (
        .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err));

    dpi_mem_port #(.ADDR_W(64), .DATA_W(32), .LATENCY(1)) u_c (
        .clk(clk), .reset(c_reset), .req_valid(c_req_valid), .req_ready(c_req_ready),
        .req_we(c_req_we), .req_addr(c_req_addr), .req_wdata(c_req_wdata), .req_wmask(c_req_wmask),
        .resp_valid(c_resp_valid), .resp_ready(c_resp_ready), .resp_rdata(c_resp_rdata), .resp_err(c_resp_err));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full LATENCY=1 transaction on u_a; returns what was visible in the response cycle.
    task automatic a_xact(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] mask, output logic vld, output logic [63:0] rdata,
                          output logic err);
        a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_wmask = mask;
        a_resp_ready = 1'b1; a_req_valid = 1'b1;
        tick();
        a_req_valid = 1'b0;
        tick();
        vld = a_resp_valid; rdata = a_resp_rdata; err = a_resp_err;
        tick();
    endtask

    task automatic c_xact(input logic we, input logic [63:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, output logic vld, output logic [31:0] rdata,
                          output logic err);
        c_req_we = we; c_req_addr = addr; c_req_wdata = wdata; c_req_wmask = mask;
        c_resp_ready = 1'b1; c_req_valid = 1'b1;
        tick();
        c_req_valid = 1'b0;
        tick();
        vld = c_resp_valid; rdata = c_resp_rdata; err = c_resp_err;
        tick();
    endtask

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
        a_req_valid = 1'b0; b_req_valid = 1'b0; c_req_valid = 1'b0;
        a_resp_ready = 1'b0; b_resp_ready = 1'b0; c_resp_ready = 1'b0;
        a_req_we = 1'b0; b_req_we = 1'b0; c_req_we = 1'b0;
        a_req_addr = 64'd0; b_req_addr = 64'd0; c_req_addr = 64'd0;
        a_req_wdata = 64'd0; b_req_wdata = 64'd0; c_req_wdata = 32'd0;
        a_req_wmask = 8'd0; b_req_wmask = 8'd0; c_req_wmask = 4'd0;
        tick(); tick();
        tests_run++;
        if ({a_req_ready, b_req_ready, c_req_ready} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_ready: got %b expected 000", {a_req_ready, b_req_ready, c_req_ready});
        end
        tests_run++;
        if ({a_resp_valid, a_resp_err, a_resp_rdata} !== 66'd0) begin
            tests_failed++; $display("FAIL reset_resp: valid=%b err=%b rdata=%h expected all 0", a_resp_valid, a_resp_err, a_resp_rdata);
        end
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        tick();
        tests_run++;
        if ({a_req_ready, b_req_ready, c_req_ready, a_resp_valid} !== 4'b1110) begin
            tests_failed++; $display("FAIL post_reset_ready: got %b expected 1110", {a_req_ready, b_req_ready, c_req_ready, a_resp_valid});
        end
    endtask

    task automatic test_store_load();
        int unsigned rc0, wc0;
        rc0 = pmem_read_count; wc0 = pmem_write_count;
        a_req_we = 1'b1; a_req_addr = 64'h8000_0010; a_req_wdata = 64'hDEADBEEF_CAFEF00D;
        a_req_wmask = 8'hFF; a_resp_ready = 1'b1; a_req_valid = 1'b1;
        tick();
        a_req_valid = 1'b0; a_req_wdata = 64'h0;
        tests_run++;
        if ({a_req_ready, a_resp_valid} !== 2'b00) begin
            tests_failed++; $display("FAIL store_wait: ready,valid=%b expected 00", {a_req_ready, a_resp_valid});
        end
        tick();
        tests_run++;
        if ({a_resp_valid, a_resp_err} !== 2'b10 || a_resp_rdata !== 64'd0 || pmem_write_count !== wc0 + 1) begin
            tests_failed++; $display("FAIL store_resp: valid=%b err=%b rdata=%h writes=%0d expected 1 0 0 %0d",
                                     a_resp_valid, a_resp_err, a_resp_rdata, pmem_write_count, wc0 + 1);
        end
        tick();
        tests_run++;
        if ({a_resp_valid, a_req_ready} !== 2'b01 || a_resp_rdata !== 64'd0) begin
            tests_failed++; $display("FAIL store_handshake: valid,ready=%b rdata=%h expected 01 0", {a_resp_valid, a_req_ready}, a_resp_rdata);
        end
        a_req_we = 1'b0; a_req_valid = 1'b1;
        tick();
        a_req_valid = 1'b0;
        tick();
        tests_run++;
        if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b0 || a_resp_rdata !== 64'hDEADBEEF_CAFEF00D || pmem_read_count !== rc0 + 1) begin
            tests_failed++; $display("FAIL load_resp: valid=%b err=%b rdata=%h reads=%0d expected 1 0 deadbeefcafef00d %0d",
                                     a_resp_valid, a_resp_err, a_resp_rdata, pmem_read_count, rc0 + 1);
        end
        tick();
    endtask

    task automatic test_masked_store();
        logic vld, err; logic [63:0] rd;
        a_xact(1'b1, 64'h8000_0020, 64'h0, 8'hFF, vld, rd, err);
        a_xact(1'b1, 64'h8000_0020, 64'h1122334455667788, 8'h0F, vld, rd, err);
        a_xact(1'b0, 64'h8000_0020, 64'h0, 8'h00, vld, rd, err);
        tests_run++;
        if (vld !== 1'b1 || rd !== 64'h0000000055667788) begin
            tests_failed++; $display("FAIL masked_store: valid=%b rdata=%h expected 1 0000000055667788", vld, rd);
        end
    endtask

    task automatic test_misaligned();
        int unsigned rc0, wc0; logic early;
        logic vld, err; logic [63:0] rd;
        rc0 = pmem_read_count; wc0 = pmem_write_count;
        b_resp_ready = 1'b1; b_req_we = 1'b0; b_req_addr = 64'h8000_0013; b_req_valid = 1'b1;
        tick();
        b_req_valid = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (b_resp_valid !== 1'b0) early = 1'b1;
            tick();
        end
        tests_run++;
        if (early !== 1'b0) begin
            tests_failed++; $display("FAIL misalign_early: resp_valid seen before acceptance+4");
        end
        tests_run++;
        if ({b_resp_valid, b_resp_err} !== 2'b11 || b_resp_rdata !== 64'd0 ||
            pmem_read_count !== rc0 || pmem_write_count !== wc0) begin
            tests_failed++; $display("FAIL misalign_resp: valid=%b err=%b rdata=%h calls=%0d expected 1 1 0 0",
                                     b_resp_valid, b_resp_err, b_resp_rdata, (pmem_read_count - rc0) + (pmem_write_count - wc0));
        end
        tick();
        tests_run++;
        if ({b_resp_valid, b_resp_err} !== 2'b00) begin
            tests_failed++; $display("FAIL misalign_clear: valid,err=%b expected 00", {b_resp_valid, b_resp_err});
        end
        wc0 = pmem_write_count;
        a_xact(1'b1, 64'h8000_0011, 64'hFFFF, 8'hFF, vld, rd, err);
        tests_run++;
        if (err !== 1'b1 || pmem_write_count !== wc0) begin
            tests_failed++; $display("FAIL misalign_store: err=%b writes=%0d expected 1 %0d", err, pmem_write_count, wc0);
        end
    endtask

    task automatic test_backpressure();
        int unsigned rc0; logic bad;
        rc0 = pmem_read_count;
        b_resp_ready = 1'b0; b_req_we = 1'b0; b_req_addr = 64'h8000_0010; b_req_valid = 1'b1;
        tick();
        b_req_valid = 1'b0; b_req_addr = 64'h8000_0020;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b0) bad = 1'b1;
            tick();
        end
        tests_run++;
        if (bad !== 1'b0) begin
            tests_failed++; $display("FAIL bp_wait: resp_valid or req_ready high before acceptance+4");
        end
        tests_run++;
        if (b_resp_valid !== 1'b1 || b_resp_rdata !== 64'hDEADBEEF_CAFEF00D) begin
            tests_failed++; $display("FAIL bp_resp: valid=%b rdata=%h expected 1 deadbeefcafef00d", b_resp_valid, b_resp_rdata);
        end
        b_req_valid = 1'b1; b_req_we = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (b_resp_valid !== 1'b1 || b_req_ready !== 1'b0 || b_resp_rdata !== 64'hDEADBEEF_CAFEF00D) bad = 1'b1;
        end
        tests_run++;
        if (bad !== 1'b0 || pmem_read_count !== rc0 + 1) begin
            tests_failed++; $display("FAIL bp_stall: unstable=%b reads=%0d expected 0 %0d", bad, pmem_read_count, rc0 + 1);
        end
        b_req_valid = 1'b0; b_req_we = 1'b0; b_resp_ready = 1'b1;
        tick();
        tests_run++;
        if (b_resp_valid !== 1'b0 || b_resp_rdata !== 64'd0) begin
            tests_failed++; $display("FAIL bp_release: valid=%b rdata=%h expected 0 0", b_resp_valid, b_resp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int unsigned wc0; logic vld, err; logic [63:0] rd;
        wc0 = pmem_write_count;
        b_req_we = 1'b1; b_req_addr = 64'h8000_0030; b_req_wdata = 64'h5555; b_req_wmask = 8'hFF;
        b_req_valid = 1'b1;
        tick();
        b_req_valid = 1'b0;
        tick();
        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;
        tests_run++;
        if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b0 || u_b.state_r !== IDLE) begin
            tests_failed++; $display("FAIL midop_reset: valid=%b ready=%b state=%0d expected 0 0 IDLE", b_resp_valid, b_req_ready, u_b.state_r);
        end
        tick();
        tests_run++;
        if (b_req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL midop_ready: got %b expected 1", b_req_ready);
        end
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (pmem_write_count !== wc0 || b_resp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL midop_nowrite: writes=%0d valid=%b expected %0d 0", pmem_write_count, b_resp_valid, wc0);
        end
        a_xact(1'b0, 64'h8000_0030, 64'h0, 8'h00, vld, rd, err);
        tests_run++;
        if (rd !== 64'd0) begin
            tests_failed++; $display("FAIL midop_mem: rdata=%h expected 0", rd);
        end
    endtask

    task automatic test_data32();
        logic vld, err; logic [63:0] rd64; logic [31:0] rd32;
        a_xact(1'b1, 64'h8000_0000, 64'hAAAABBBB_CCCCDDDD, 8'hFF, vld, rd64, err);
        c_xact(1'b0, 64'h8000_0004, 32'h0, 4'h0, vld, rd32, err);
        tests_run++;
        if (vld !== 1'b1 || err !== 1'b0 || rd32 !== 32'hAAAABBBB) begin
            tests_failed++; $display("FAIL d32_load_hi: valid=%b err=%b rdata=%h expected 1 0 aaaabbbb", vld, err, rd32);
        end
        c_xact(1'b0, 64'h8000_0000, 32'h0, 4'h0, vld, rd32, err);
        tests_run++;
        if (rd32 !== 32'hCCCCDDDD) begin
            tests_failed++; $display("FAIL d32_load_lo: rdata=%h expected ccccdddd", rd32);
        end
        c_xact(1'b1, 64'h8000_0004, 32'h12345678, 4'hF, vld, rd32, err);
        a_xact(1'b0, 64'h8000_0000, 64'h0, 8'h00, vld, rd64, err);
        tests_run++;
        if (rd64 !== 64'h12345678_CCCCDDDD) begin
            tests_failed++; $display("FAIL d32_store: rdata=%h expected 12345678ccccdddd", rd64);
        end
        c_xact(1'b0, 64'h8000_0002, 32'h0, 4'h0, vld, rd32, err);
        tests_run++;
        if (err !== 1'b1 || rd32 !== 32'd0) begin
            tests_failed++; $display("FAIL d32_misalign: err=%b rdata=%h expected 1 0", err, rd32);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned rc0; int acc;
        rc0 = pmem_read_count; acc = 0;
        a_req_we = 1'b0; a_req_addr = 64'h8000_0010; a_resp_ready = 1'b1; a_req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (a_req_ready && a_req_valid) acc++;
            tick();
        end
        a_req_valid = 1'b0;
        tick();
        tests_run++;
        if (acc !== 3 || pmem_read_count !== rc0 + 3) begin
            tests_failed++; $display("FAIL back_to_back: accepts=%0d reads=%0d expected 3 3", acc, pmem_read_count - rc0);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_masked_store();
        test_misaligned();
        test_backpressure();
        test_reset_midop();
        test_data32();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
